ls298_demux: RTL and testbench

Storage demultiplexer: the receiving end of a 74LS298-style time-multiplexed nibble bus. It takes a nibble stream plus the bank select that drove the upstream mux and steers each strobed nibble into bank 0 or bank 1. It pairs the banks into one output word with a valid/ready handshake, and counts delivered pairs. It sits on the consumer side of any path in the core where two 4-bit sources share one 298-muxed bus, for example graphics/ROM data split back into high and low halves.

---
 rtl/ls298_demux.sv | 149 ++++++++++++++
 tb/tb_ls298_demux.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ls298_demux.sv
// ls298_demux: consumer side of a 74LS298-style muxed nibble bus.
// Strobed nibbles are steered into bank 0 or bank 1 by the select bit.
// A complete pair is presented on q0/q1 with a valid/ready handshake.
// Consumed pairs are counted modulo 2^CNT_W. All state moves on the
// falling clock edge, as the 298 does.
module ls298_demux #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             stb,
  input  logic             rdy,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic             valid,
  output logic             ovf,
  output logic [CNT_W-1:0] pairs
);

  // Capture progress. HAVE0/HAVE1 double as the h0/h1 "bank captured" flags.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HAVE0 = 2'd1;
  localparam logic [1:0] HAVE1 = 2'd2;
  localparam logic [1:0] FULL  = 2'd3;

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] b0, b0_nx;
  logic [WIDTH-1:0] b1, b1_nx;
  logic [WIDTH-1:0] q0_nx, q1_nx;
  logic             valid_nx;
  logic             ovf_nx;
  logic [CNT_W-1:0] pairs_nx;
  logic             consume;
  logic             h0, h1;

  // Delivered-pair counter step; wraps naturally at 2^CNT_W.
  function automatic logic [CNT_W-1:0] pairs_inc(input logic [CNT_W-1:0] c);
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // The capture flags are pure views of the state register.
  assign h0 = (state == HAVE0);
  assign h1 = (state == HAVE1);

  // A transfer happens only while a pair is actually held.
  assign consume = valid & rdy;

  // Next-state and datapath steering.
  always_comb begin
    state_nx = state;
    b0_nx    = b0;
    b1_nx    = b1;
    q0_nx    = q0;
    q1_nx    = q1;
    ovf_nx   = ovf;
    pairs_nx = pairs;
    case (state)
      EMPTY: begin
        if (stb) begin
          if (s) begin
            b1_nx    = d;
            state_nx = HAVE1;
          end else begin
            b0_nx    = d;
            state_nx = HAVE0;
          end
        end
      end
      HAVE0: begin
        if (stb) begin
          if (s) begin
            // Second half arrives: pair the held bank-0 nibble with the bus.
            b1_nx    = d;
            q0_nx    = b0;
            q1_nx    = d;
            state_nx = FULL;
          end else begin
            // Repeated bank: the latest nibble wins silently.
            b0_nx    = d;
          end
        end
      end
      HAVE1: begin
        if (stb) begin
          if (!s) begin
            b0_nx    = d;
            q0_nx    = d;
            q1_nx    = b1;
            state_nx = FULL;
          end else begin
            b1_nx    = d;
          end
        end
      end
      default: begin
        if (consume) begin
          pairs_nx = pairs_inc(pairs);
          // A strobe in the consume cycle starts the next pair at once.
          if (stb) begin
            if (s) begin
              b1_nx    = d;
              state_nx = HAVE1;
            end else begin
              b0_nx    = d;
              state_nx = HAVE0;
            end
          end else begin
            state_nx = EMPTY;
          end
        end else if (stb) begin
          // No room for the nibble: drop it and remember that it happened.
          ovf_nx = 1'b1;
        end
      end
    endcase
    valid_nx = (state_nx == FULL);
  end

  // Falling-edge state update with immediate asynchronous clear.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= EMPTY;
      b0    <= '0;
      b1    <= '0;
      q0    <= '0;
      q1    <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      pairs <= '0;
    end else begin
      state <= state_nx;
      b0    <= b0_nx;
      b1    <= b1_nx;
      q0    <= q0_nx;
      q1    <= q1_nx;
      valid <= valid_nx;
      ovf   <= ovf_nx;
      pairs <= pairs_nx;
    end
  end

  // h0/h1 are kept for visibility in waveforms and future status ports.
  logic unused_flags;
  assign unused_flags = h0 ^ h1;

endmodule

// File: tb/tb_ls298_demux.sv
// Testbench for ls298_demux: directed scenarios plus random traffic,
// checked against a bank/pair reference model through a scoreboard queue.
module tb_ls298_demux;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             clr_n;
  logic [WIDTH-1:0] d;
  logic             s;
  logic             stb;
  logic             rdy;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic             valid;
  logic             ovf;
  logic [CNT_W-1:0] pairs;

  ls298_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr_n(clr_n), .d(d), .s(s), .stb(stb), .rdy(rdy),
    .q0(q0), .q1(q1), .valid(valid), .ovf(ovf), .pairs(pairs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: two banks, which banks hold a nibble, and whether a
  // complete pair is waiting for the consumer.
  int m_bank [2];
  bit m_has  [2];
  bit m_valid;
  bit m_ovf;
  int m_pairs;
  int m_q0, m_q1;
  int exp_q[$];   // expected pairs, packed as q0*16+q1

  task automatic model_reset();
    m_bank[0] = 0; m_bank[1] = 0;
    m_has[0] = 0;  m_has[1] = 0;
    m_valid = 0; m_ovf = 0; m_pairs = 0;
    m_q0 = 0; m_q1 = 0;
    exp_q.delete();
  endtask

  // Outcome of one falling edge given the inputs in force at it.
  task automatic model_step(input int dv, input int sv, input bit st, input bit rd);
    if (m_valid) begin
      if (rd) begin
        m_pairs = (m_pairs + 1) % (1 << CNT_W);
        m_valid = 0;
        m_has[0] = 0; m_has[1] = 0;
        if (st) begin
          m_bank[sv] = dv;
          m_has[sv]  = 1;
        end
      end else if (st) begin
        m_ovf = 1;
      end
    end else if (st) begin
      m_bank[sv] = dv;
      m_has[sv]  = 1;
      if (m_has[0] && m_has[1]) begin
        m_valid = 1;
        m_q0 = m_bank[0];
        m_q1 = m_bank[1];
        exp_q.push_back(m_q0 * 16 + m_q1);
        m_has[0] = 0; m_has[1] = 0;
      end
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic step(input int dv, input int sv, input bit st, input bit rd);
    @(posedge clk);
    d = dv[WIDTH-1:0]; s = sv[0]; stb = st; rdy = rd;
    model_step(dv, sv, st, rd);
  endtask

  // Asynchronous reset between edges, checked before any clock edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    stb = 0; rdy = 0;
    #2 clr_n = 0;
    #1;
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_ovf"},   int'(ovf),   0);
    check({tag, "_pairs"}, int'(pairs), 0);
    check({tag, "_q"},     int'({q0, q1}), 0);
    model_reset();
    clr_n = 1;
  endtask

  // Monitor: compares the DUT with the model just after every active edge
  // and pops the scoreboard whenever a new pair is presented.
  bit mon_on = 0;
  initial begin
    bit prev_valid = 0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_on) begin
        check("valid", int'(valid), int'(m_valid));
        check("ovf",   int'(ovf),   int'(m_ovf));
        check("pairs", int'(pairs), m_pairs);
        check("q_hold", int'({q0, q1}), m_q0 * 16 + m_q1);
        if (valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_pair", int'({q0, q1}), -1);
          end else begin
            check("sb_pair", int'({q0, q1}), exp_q.pop_front());
          end
        end
        prev_valid = valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit %0d", $time, 200000);
    $fatal(1);
  end

  initial begin
    d = 0; s = 0; stb = 0; rdy = 0;
    clr_n = 0;
    model_reset();
    #3;
    check("rst_valid", int'(valid), 0);
    check("rst_ovf",   int'(ovf),   0);
    check("rst_pairs", int'(pairs), 0);
    check("rst_q",     int'({q0, q1}), 0);
    #4 clr_n = 1;
    mon_on = 1;

    // Basic pair, then a single-edge consume.
    step(5, 0, 1, 0);
    step(10, 1, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Same-bank overwrite.
    step(3, 0, 1, 0);
    step(7, 0, 1, 0);
    step(1, 1, 1, 0);
    step(0, 0, 0, 0);

    // Overflow while full, then consume together with a new strobe.
    step(15, 0, 1, 0);
    step(0, 0, 0, 0);
    step(2, 1, 1, 1);
    step(0, 0, 0, 0);
    step(9, 0, 1, 0);
    step(0, 0, 0, 1);

    // Reset in HAVE0, then a lone bank-1 strobe must not complete a pair.
    step(6, 0, 1, 0);
    async_reset("rst_mid");
    step(4, 1, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Counter wrap: 256 back-to-back pairs with rdy held high.
    async_reset("rst_wrap");
    for (int i = 0; i < 256; i++) begin
      step(i % 16, 0, 1, 1);
      step((i / 16) % 16, 1, 1, 1);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("wrap_pairs", int'(pairs), 0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    @(negedge clk);
    #2;
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
